fifo_wr_arbiter: RTL and testbench

Round-robin, burst-aware write arbiter that shares the write port of one synchronous FIFO among N requesters. It grants one requester at a time and steers that requester's data onto the FIFO write port. It never issues a write while the FIFO reports full. It sits directly in front of the FIFO's `wr`/`Wdata`/`full` pins; the read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin, burst-aware arbiter that shares the write port of one
// synchronous FIFO among N requesters. One requester is granted at a time
// and its data slice is steered onto the FIFO write port in the same cycle.
// No write is issued while the FIFO reports full.
//
// Ports:
//   clk        - clock, rising edge
//   reset_n    - synchronous active-low reset
//   req        - per-requester beat request (bit i = requester i)
//   last       - per-requester end-of-burst marker, qualified by req
//   wdata_in   - requester i data at [i*WIDTH +: WIDTH]
//   grant      - one-hot or zero grant vector
//   fifo_full  - FIFO full flag
//   fifo_wr    - FIFO write enable
//   fifo_wdata - FIFO write data (zero when not writing)
//   busy       - high while a burst is locked to one requester
//   owner      - index of the locked requester, valid when busy
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int  WIDTH     = 8,
    parameter int  N         = 4,
    parameter int  MAX_BURST = 4,
    localparam int PW        = (N > 1) ? $clog2(N) : 1,
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         last,
    input  logic [N*WIDTH-1:0]   wdata_in,
    output logic [N-1:0]         grant,
    input  logic                 fifo_full,
    output logic                 fifo_wr,
    output logic [WIDTH-1:0]     fifo_wdata,
    output logic                 busy,
    output logic [PW-1:0]        owner
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   rrPtr_q, rrPtr_d;
    logic [CW-1:0]   beatCnt_q, beatCnt_d;

    logic [PW-1:0]   selIdx;
    logic            selValid;
    int              idx;

    // Wrap-around successor of a requester index.
    function automatic logic [PW-1:0] nextIdx(input logic [PW-1:0] i);
        if (int'(i) == N - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // Pick the requester that may write this cycle. A locked burst keeps
    // its grant even while the owner has no beat, so the lock survives
    // bubbles; otherwise search round-robin starting at rrPtr_q.
    always_comb begin
        selIdx   = '0;
        selValid = 1'b0;
        grant    = '0;
        idx      = 0;
        if (reset_n && !fifo_full) begin
            if (state_q == BURST) begin
                selIdx   = owner_q;
                selValid = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (int'(rrPtr_q) + k) % N;
                    if (!selValid && req[idx]) begin
                        selIdx   = PW'(idx);
                        selValid = 1'b1;
                    end
                end
            end
        end
        if (selValid) begin
            grant[selIdx] = 1'b1;
        end
    end

    // Zero-latency write port: full is seen in the same cycle, so an
    // accepted beat can never overflow the FIFO.
    assign fifo_wr    = |(req & grant);
    assign fifo_wdata = fifo_wr ? wdata_in[selIdx*WIDTH +: WIDTH] : '0;

    // State only advances on an accepted beat; bubbles and full cycles
    // leave every register untouched.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rrPtr_d   = rrPtr_q;
        beatCnt_d = beatCnt_q;
        if (fifo_wr) begin
            case (state_q)
                IDLE: begin
                    if (last[selIdx] || MAX_BURST == 1) begin
                        rrPtr_d = nextIdx(selIdx);
                    end else begin
                        state_d   = BURST;
                        owner_d   = selIdx;
                        beatCnt_d = CW'(1);
                    end
                end
                BURST: begin
                    // Forced release at MAX_BURST keeps one requester from
                    // hogging the FIFO; its remaining beats re-arbitrate.
                    if ((int'(beatCnt_q) + 1 == MAX_BURST) || last[owner_q]) begin
                        state_d   = IDLE;
                        rrPtr_d   = nextIdx(owner_q);
                        beatCnt_d = '0;
                    end else begin
                        beatCnt_d = beatCnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rrPtr_q   <= '0;
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rrPtr_q   <= rrPtr_d;
            beatCnt_q <= beatCnt_d;
        end
    end

    // busy is masked while reset is asserted so a mid-burst reset shows
    // idle immediately rather than one edge later.
    assign busy  = (state_q == BURST) && reset_n;
    assign owner = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed testbench for fifo_wr_arbiter. The driver applies one vector per
// cycle and pushes the hand-computed expected outputs into a queue; a
// monitor on the falling edge pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int WIDTH = 8;
    localparam int N     = 4;

    logic               clk;
    logic               reset_n;
    logic [N-1:0]       req;
    logic [N-1:0]       last;
    logic [N*WIDTH-1:0] wdata_in;
    logic [N-1:0]       grant;
    logic               fifo_full;
    logic               fifo_wr;
    logic [WIDTH-1:0]   fifo_wdata;
    logic               busy;
    logic [1:0]         owner;

    typedef struct packed {
        logic [N-1:0]     grant;
        logic             wr;
        logic [WIDTH-1:0] wdata;
        logic             busy;
        logic             checkOwner;
        logic [1:0]       owner;
    } expect_t;

    expect_t expQ[$];
    int      compared   = 0;
    int      mismatched = 0;
    int      vecNum     = 0;
    logic [5:0] tag     = 6'd0;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .N(N), .MAX_BURST(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .last       (last),
        .wdata_in   (wdata_in),
        .grant      (grant),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .busy       (busy),
        .owner      (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge and queue the
    // expected outputs for that cycle. Each slice carries a per-cycle tag
    // plus its index so a wrong steering choice shows up in fifo_wdata.
    task automatic applyStimulus(input logic rstn, input logic [N-1:0] r,
                                 input logic [N-1:0] l, input logic full,
                                 input logic [N-1:0] expGrant, input logic expBusy,
                                 input logic [1:0] expOwner);
        expect_t e;
        @(posedge clk);
        #1;
        tag       = tag + 6'd1;
        reset_n   = rstn;
        req       = r;
        last      = l;
        fifo_full = full;
        for (int i = 0; i < N; i++) begin
            wdata_in[i*WIDTH +: WIDTH] = {tag, 2'(i)};
        end
        e.grant      = expGrant;
        e.wr         = |(r & expGrant);
        e.wdata      = '0;
        if (e.wr) begin
            for (int i = 0; i < N; i++) begin
                if (expGrant[i]) e.wdata = {tag, 2'(i)};
            end
        end
        e.busy       = expBusy;
        e.checkOwner = expBusy;
        e.owner      = expOwner;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL vec%0d %s: got %h, expected %h", vecNum, name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents in each cycle that the
    // driver has queued an expectation for.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            expect_t e;
            e = expQ.pop_front();
            vecNum++;
            checkOutput("grant", WIDTH'(grant), WIDTH'(e.grant));
            checkOutput("fifo_wr", WIDTH'(fifo_wr), WIDTH'(e.wr));
            checkOutput("fifo_wdata", fifo_wdata, e.wdata);
            checkOutput("busy", WIDTH'(busy), WIDTH'(e.busy));
            if (e.checkOwner) checkOutput("owner", WIDTH'(owner), WIDTH'(e.owner));
        end
    end

    initial begin
        reset_n   = 1'b0;
        req       = '0;
        last      = '0;
        fifo_full = 1'b0;
        wdata_in  = '0;

        // Reset with everyone requesting: nothing granted or written.
        applyStimulus(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 2'd0);
        applyStimulus(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 2'd0);

        // Single-beat round robin from rr_ptr=0.
        applyStimulus(1, 4'b1111, 4'b1111, 0, 4'b0001, 0, 2'd0);
        applyStimulus(1, 4'b1111, 4'b1111, 0, 4'b0010, 0, 2'd0);
        applyStimulus(1, 4'b1111, 4'b1111, 0, 4'b0100, 0, 2'd0);
        applyStimulus(1, 4'b1111, 4'b1111, 0, 4'b1000, 0, 2'd0);
        applyStimulus(1, 4'b1111, 4'b1111, 0, 4'b0001, 0, 2'd0);
        applyStimulus(1, 4'b1111, 4'b1111, 0, 4'b0010, 0, 2'd0);
        applyStimulus(1, 4'b1111, 4'b1111, 0, 4'b0100, 0, 2'd0);
        applyStimulus(1, 4'b1111, 4'b1111, 0, 4'b1000, 0, 2'd0);

        // Move rr_ptr to 2, then a 3-beat burst from requester 2 with last
        // on beat 3; the next grant goes to requester 3.
        applyStimulus(1, 4'b0010, 4'b0010, 0, 4'b0010, 0, 2'd0);
        applyStimulus(1, 4'b1111, 4'b0000, 0, 4'b0100, 0, 2'd0);
        applyStimulus(1, 4'b1111, 4'b0000, 0, 4'b0100, 1, 2'd2);
        applyStimulus(1, 4'b1111, 4'b0100, 0, 4'b0100, 1, 2'd2);
        applyStimulus(1, 4'b1111, 4'b1111, 0, 4'b1000, 0, 2'd0);

        // Forced release after 4 beats from requester 1, one beat from 3,
        // then requester 1 gets a fresh 4-beat burst.
        applyStimulus(1, 4'b1010, 4'b0000, 0, 4'b0010, 0, 2'd0);
        applyStimulus(1, 4'b1010, 4'b0000, 0, 4'b0010, 1, 2'd1);
        applyStimulus(1, 4'b1010, 4'b0000, 0, 4'b0010, 1, 2'd1);
        applyStimulus(1, 4'b1010, 4'b0000, 0, 4'b0010, 1, 2'd1);
        applyStimulus(1, 4'b1010, 4'b1000, 0, 4'b1000, 0, 2'd0);
        applyStimulus(1, 4'b1010, 4'b1000, 0, 4'b0010, 0, 2'd0);
        applyStimulus(1, 4'b1010, 4'b1000, 0, 4'b0010, 1, 2'd1);
        applyStimulus(1, 4'b1010, 4'b1000, 0, 4'b0010, 1, 2'd1);
        applyStimulus(1, 4'b1010, 4'b1000, 0, 4'b0010, 1, 2'd1);

        // Full for 3 cycles during beat 2 of requester 0's burst.
        applyStimulus(1, 4'b0001, 4'b0000, 0, 4'b0001, 0, 2'd0);
        applyStimulus(1, 4'b0001, 4'b0000, 1, 4'b0000, 1, 2'd0);
        applyStimulus(1, 4'b0001, 4'b0000, 1, 4'b0000, 1, 2'd0);
        applyStimulus(1, 4'b0001, 4'b0000, 1, 4'b0000, 1, 2'd0);
        applyStimulus(1, 4'b0001, 4'b0000, 0, 4'b0001, 1, 2'd0);
        applyStimulus(1, 4'b0001, 4'b0001, 0, 4'b0001, 1, 2'd0);

        // Owner 1 bubbles for two cycles, writes once, then reset mid-burst.
        applyStimulus(1, 4'b0010, 4'b0000, 0, 4'b0010, 0, 2'd0);
        applyStimulus(1, 4'b0000, 4'b0000, 0, 4'b0010, 1, 2'd1);
        applyStimulus(1, 4'b0000, 4'b0000, 0, 4'b0010, 1, 2'd1);
        applyStimulus(1, 4'b0110, 4'b0000, 0, 4'b0010, 1, 2'd1);
        applyStimulus(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 2'd0);
        applyStimulus(1, 4'b1100, 4'b1100, 0, 4'b0100, 0, 2'd0);
        applyStimulus(1, 4'b1111, 4'b1111, 0, 4'b1000, 0, 2'd0);

        // last on non-requesting lines is ignored: requester 2 locks.
        applyStimulus(1, 4'b0100, 4'b1011, 0, 4'b0100, 0, 2'd0);
        applyStimulus(1, 4'b0100, 4'b0100, 0, 4'b0100, 1, 2'd2);

        // Full while idle blocks arbitration; rr_ptr=3 afterwards.
        applyStimulus(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 2'd0);
        applyStimulus(1, 4'b1111, 4'b1111, 0, 4'b1000, 0, 2'd0);

        @(posedge clk);
        #1;
        req = '0;
        @(negedge clk);
        #1;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
